// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized ro_in rising edges over a gate window of clk cycles.
// Optional macro RO_CONTINUOUS_EN makes measurements free-run after the first start.
module ro_freq_counter #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ro_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic [CNT_W-1:0]  count,
    output logic              valid,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  ACC_MAX  = '1;
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               r_edge;
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]   r_acc;
    logic               r_acc_ovf;
    logic [CNT_W-1:0]   r_count;
    logic               r_valid;
    logic               r_busy;
    logic               r_overflow;

    logic [CNT_W-1:0]   w_acc_next;
    logic               w_acc_ovf_next;
    logic               w_gate_last;

    // Two flops of metastability settling, then a registered rising-edge pulse:
    // the pulse is high three cycles after ro_in rises.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    // Saturating accumulate of this cycle's edge pulse.
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        w_acc_next     = r_acc;
        w_acc_ovf_next = r_acc_ovf;
        if (r_edge) begin
            if (r_acc == ACC_MAX) begin
                w_acc_ovf_next = 1'b1;
            end else begin
                w_acc_next = r_acc + CNT_W'(1);
            end
        end
    end

    assign w_gate_last = (r_gate_cnt == GATE_ONE);

    // Result and valid are registered on entry to DONE so valid is high
    // during the DONE cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gate_cnt <= '0;
            r_acc      <= '0;
            r_acc_ovf  <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc     <= '0;
                        r_acc_ovf <= 1'b0;
                        r_busy    <= 1'b1;
                        if (gate_cycles != '0) begin
                            r_gate_cnt <= gate_cycles;
                            r_state    <= S_GATE;
                        end else begin
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                            r_valid    <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_GATE: begin
                    r_acc      <= w_acc_next;
                    r_acc_ovf  <= w_acc_ovf_next;
                    r_gate_cnt <= r_gate_cnt - GATE_ONE;
                    if (w_gate_last) begin
                        r_count    <= w_acc_next;
                        r_overflow <= w_acc_ovf_next;
                        r_valid    <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef RO_CONTINUOUS_EN
                    if (gate_cycles != '0) begin
                        r_gate_cnt <= gate_cycles;
                        r_acc      <= '0;
                        r_acc_ovf  <= 1'b0;
                        r_state    <= S_GATE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
`else
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign count    = r_count;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter (CNT_W=8) against a rise-counting reference model.
// Build with RO_CONTINUOUS_EN defined to exercise the free-running mode instead of the single-shot tests.
`timescale 1ns/1ps
module tb_ro_freq_counter;

    localparam int GATE_W = 16;
    localparam int CNT_W  = 8;
    localparam int SAT    = (1 << CNT_W) - 1;
    localparam int HIST   = 50000;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic              ro_in       = 1'b0;
    logic              start       = 1'b0;
    logic [GATE_W-1:0] gate_cycles = '0;
    logic [CNT_W-1:0]  count;
    logic              valid;
    logic              busy;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    int cyc       = 0;
    int ro_period = 4;
    bit ro_hist [0:HIST-1];

    ro_freq_counter #(.GATE_W(GATE_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ro_in      (ro_in),
        .start      (start),
        .gate_cycles(gate_cycles),
        .count      (count),
        .valid      (valid),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Cycle c is the interval after the c-th rising edge; ro_in is driven once per cycle.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (ro_period == 0) ro_in = 1'($urandom_range(0, 1));
        else                ro_in = (cyc % ro_period) < (ro_period / 2);
        if (cyc < HIST) ro_hist[cyc] = ro_in;
    end

    // A rise of ro_in in cycle r is seen by the counter in cycle r+3; a window started
    // in cycle k spans cycles k+1..k+n, so it counts rises in cycles k-2..k+n-3.
    function automatic int model_rises(input int k, input int n);
        int c = 0;
        for (int r = k - 2; r <= k + n - 3; r++) begin
            if (r >= 1 && r < HIST && ro_hist[r] && !ro_hist[r-1]) c++;
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] model_count(input int rises);
        return (rises > SAT) ? CNT_W'(SAT) : CNT_W'(rises);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure(input int n, input int inj_at, input int inj_n, input bit scramble,
                           output int k, output int nvalid, output int vcyc, output int nbusy,
                           output logic [CNT_W-1:0] vcount, output logic vovf, output bit hold_ok);
        logic [CNT_W-1:0] prev;
        @(negedge clk);
        prev        = count;
        start       = 1'b1;
        gate_cycles = GATE_W'(n);
        k           = cyc;
        nvalid      = 0;
        vcyc        = -1;
        nbusy       = 0;
        vcount      = 'x;
        vovf        = 1'bx;
        hold_ok     = 1'b1;
        for (int i = 1; i <= n + 4; i++) begin
            @(negedge clk);
            start = (i == inj_at);
            if (i == inj_at)  gate_cycles = GATE_W'(inj_n);
            else if (scramble) gate_cycles = GATE_W'($urandom);
            if (busy === 1'b1) nbusy++;
            if (valid === 1'b1) begin
                nvalid++;
                vcyc   = cyc;
                vcount = count;
                vovf   = overflow;
            end else if (nvalid == 0 && count !== prev) begin
                hold_ok = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks += 4;
        if (count !== '0)     begin errors++; $display("FAIL reset_count got=%0h exp=0", count); end
        if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        idle(2);
        rst_n = 1'b1;
        idle(8);
        checks += 2;
        if (busy !== 1'b0)  begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
        if (valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", valid); end
    endtask

    task automatic test_basic;
        int k, nv, vc, nb, exp_r;
        logic [CNT_W-1:0] vcnt;
        logic vo;
        bit hold;
        ro_period = 4;
        idle(10);
        measure(100, -1, 0, 1'b0, k, nv, vc, nb, vcnt, vo, hold);
        exp_r = model_rises(k, 100);
        checks += 7;
        if (nv != 1)          begin errors++; $display("FAIL basic_valid_pulses got=%0d exp=1", nv); end
        if (vc != k + 101)    begin errors++; $display("FAIL basic_valid_cycle got=%0d exp=%0d", vc, k + 101); end
        if (vcnt !== model_count(exp_r)) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", vcnt, model_count(exp_r)); end
        if (!(vcnt >= 24 && vcnt <= 26)) begin errors++; $display("FAIL basic_count_range got=%0d exp=24..26", vcnt); end
        if (vo !== 1'b0)      begin errors++; $display("FAIL basic_overflow got=%b exp=0", vo); end
        if (nb != 101)        begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=101", nb); end
        if (!hold)            begin errors++; $display("FAIL basic_hold_before_valid got=changed exp=held"); end
        idle(5);
        checks++;
        if (count !== vcnt)   begin errors++; $display("FAIL basic_count_held got=%0d exp=%0d", count, vcnt); end
    endtask

    task automatic test_zero_gate;
        int k, nv, vc, nb;
        logic [CNT_W-1:0] vcnt;
        logic vo;
        bit hold;
        idle(5);
        measure(0, -1, 0, 1'b0, k, nv, vc, nb, vcnt, vo, hold);
        checks += 5;
        if (nv != 1)       begin errors++; $display("FAIL zero_valid_pulses got=%0d exp=1", nv); end
        if (vc != k + 1)   begin errors++; $display("FAIL zero_valid_cycle got=%0d exp=%0d", vc, k + 1); end
        if (vcnt !== '0)   begin errors++; $display("FAIL zero_count got=%0d exp=0", vcnt); end
        if (vo !== 1'b0)   begin errors++; $display("FAIL zero_overflow got=%b exp=0", vo); end
        if (nb != 1)       begin errors++; $display("FAIL zero_busy_cycles got=%0d exp=1", nb); end
    endtask

    task automatic test_saturation;
        int k, nv, vc, nb;
        logic [CNT_W-1:0] vcnt;
        logic vo;
        bit hold;
        ro_period = 2;
        idle(10);
        measure(1000, -1, 0, 1'b0, k, nv, vc, nb, vcnt, vo, hold);
        checks += 4;
        if (nv != 1)          begin errors++; $display("FAIL sat_valid_pulses got=%0d exp=1", nv); end
        if (vc != k + 1001)   begin errors++; $display("FAIL sat_valid_cycle got=%0d exp=%0d", vc, k + 1001); end
        if (vcnt !== CNT_W'(SAT)) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", vcnt, SAT); end
        if (vo !== 1'b1)      begin errors++; $display("FAIL sat_overflow got=%b exp=1", vo); end
    endtask

    task automatic test_reset_abort;
        int nv = 0;
        int nb = 0;
        ro_period = 4;
        idle(10);
        @(negedge clk);
        start       = 1'b1;
        gate_cycles = GATE_W'(100);
        @(negedge clk);
        start = 1'b0;
        idle(49);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (count !== '0)      begin errors++; $display("FAIL abort_count got=%0d exp=0", count); end
        if (valid !== 1'b0)    begin errors++; $display("FAIL abort_valid got=%b exp=0", valid); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL abort_overflow got=%b exp=0", overflow); end
        idle(3);
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
            if (busy === 1'b1)  nb++;
        end
        checks += 3;
        if (nv != 0)       begin errors++; $display("FAIL abort_no_valid got=%0d exp=0", nv); end
        if (nb != 0)       begin errors++; $display("FAIL abort_stays_idle got=%0d exp=0", nb); end
        if (count !== '0)  begin errors++; $display("FAIL abort_count_after got=%0d exp=0", count); end
    endtask

    task automatic test_busy_ignore;
        int k, nv, vc, nb, exp_r;
        logic [CNT_W-1:0] vcnt;
        logic vo;
        bit hold;
        ro_period = 4;
        idle(10);
        measure(40, 10, 5, 1'b0, k, nv, vc, nb, vcnt, vo, hold);
        exp_r = model_rises(k, 40);
        checks += 5;
        if (nv != 1)        begin errors++; $display("FAIL ignore_valid_pulses got=%0d exp=1", nv); end
        if (vc != k + 41)   begin errors++; $display("FAIL ignore_valid_cycle got=%0d exp=%0d", vc, k + 41); end
        if (vcnt !== model_count(exp_r)) begin errors++; $display("FAIL ignore_count got=%0d exp=%0d", vcnt, model_count(exp_r)); end
        if (nb != 41)       begin errors++; $display("FAIL ignore_busy_cycles got=%0d exp=41", nb); end
        if (!hold)          begin errors++; $display("FAIL ignore_hold_before_valid got=changed exp=held"); end
    endtask

    task automatic test_random;
        int k, nv, vc, nb, n, exp_r;
        logic [CNT_W-1:0] vcnt;
        logic vo;
        bit hold;
        int periods [6] = '{0, 2, 3, 4, 5, 7};
        for (int it = 0; it < 10; it++) begin
            ro_period = periods[$urandom_range(0, 5)];
            n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 700));
            idle(6);
            measure(n, -1, 0, 1'b1, k, nv, vc, nb, vcnt, vo, hold);
            exp_r = (n == 0) ? 0 : model_rises(k, n);
            checks += 4;
            if (nv != 1)        begin errors++; $display("FAIL rand%0d_valid_pulses got=%0d exp=1", it, nv); end
            if (vc != k + n + 1) begin errors++; $display("FAIL rand%0d_valid_cycle got=%0d exp=%0d", it, vc, k + n + 1); end
            if (vcnt !== model_count(exp_r)) begin errors++; $display("FAIL rand%0d_count n=%0d got=%0d exp=%0d", it, n, vcnt, model_count(exp_r)); end
            if (vo !== (exp_r > SAT)) begin errors++; $display("FAIL rand%0d_overflow got=%b exp=%b", it, vo, exp_r > SAT); end
        end
    endtask

    task automatic test_continuous;
        int k;
        int vcyc [$];
        int vcnt [$];
        int vovf [$];
        int busy_drop = 0;
        logic busy_end = 1'bx;
        int exp_r;
        ro_period = 4;
        idle(10);
        @(negedge clk);
        start       = 1'b1;
        gate_cycles = GATE_W'(20);
        k           = cyc;
        for (int i = 1; i <= 87; i++) begin
            @(negedge clk);
            if (i == 1)  start = 1'b0;
            if (i == 64) gate_cycles = '0;
            if (valid === 1'b1) begin
                vcyc.push_back(cyc);
                vcnt.push_back(int'(count));
                vovf.push_back(int'(overflow));
            end
            if (i <= 84 && busy !== 1'b1) busy_drop++;
            if (i == 86) busy_end = busy;
        end
        checks += 3;
        if (vcyc.size() != 4) begin errors++; $display("FAIL cont_valid_pulses got=%0d exp=4", vcyc.size()); end
        if (busy_drop != 0)   begin errors++; $display("FAIL cont_busy_drops got=%0d exp=0", busy_drop); end
        if (busy_end !== 1'b0) begin errors++; $display("FAIL cont_busy_after_stop got=%b exp=0", busy_end); end
        for (int j = 0; j < vcyc.size() && j < 4; j++) begin
            exp_r = model_rises(k + 21 * j, 20);
            checks += 4;
            if (vcyc[j] != k + 21 * (j + 1)) begin errors++; $display("FAIL cont%0d_valid_cycle got=%0d exp=%0d", j, vcyc[j], k + 21 * (j + 1)); end
            if (vcnt[j] != exp_r)            begin errors++; $display("FAIL cont%0d_count got=%0d exp=%0d", j, vcnt[j], exp_r); end
            if (vcnt[j] < 4 || vcnt[j] > 6)  begin errors++; $display("FAIL cont%0d_count_range got=%0d exp=4..6", j, vcnt[j]); end
            if (vovf[j] != 0)                begin errors++; $display("FAIL cont%0d_overflow got=%0d exp=0", j, vovf[j]); end
        end
    endtask

    initial begin
        test_reset();
`ifdef RO_CONTINUOUS_EN
        test_continuous();
        test_reset_abort();
`else
        test_basic();
        test_reset_abort();
        test_zero_gate();
        test_saturation();
        test_busy_ignore();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 Parameters SHALL be as follows.
  - GATE_W, default 16: width of the gate-length input and gate counter.
  - CNT_W, default 16: width of the edge counter and result.
REQ-002 Ports SHALL be as follows.
  - clk  input  1  system clock; all state on rising edge.
  - rst_n  input  1  reset; asynchronous assert, active-low.
  - ro_in  input  1  selected ring-oscillator output, asynchronous to clk.
  - start  input  1  single-cycle request to begin one measurement.
  - gate_cycles  input  GATE_W  gate window length in clk cycles; sampled with start.
  - count  output  CNT_W  last completed measurement result.
  - valid  output  1  one-cycle pulse: count just updated.
  - busy  output  1  high while a measurement is in progress.
  - overflow  output  1  last result saturated.
REQ-003 The block SHALL have one clock, clk, and the reset SHALL be asynchronous and active-low, named rst_n.

Function
REQ-004 ro_in SHALL pass through a 2-flop synchronizer, then a 1-flop rising-edge detector; a detected edge is a one-cycle pulse, 3 cycles after the ro_in rise.
REQ-005 The FSM SHALL have states IDLE, GATE and DONE; the state encoding is free.
REQ-006 In IDLE with start=1 and gate_cycles=N>0, the block SHALL take the following actions on that edge.
  - Load the gate counter with N.
  - Clear the edge accumulator and its overflow flag.
  - Enter GATE.
REQ-007 In IDLE with start=1 and gate_cycles=0, the block SHALL enter DONE directly, with accumulator 0 and overflow 0.
REQ-008 In GATE, each cycle SHALL add 1 to the accumulator if the edge pulse is high, and decrement the gate counter.
REQ-009 The block SHALL leave GATE for DONE on the cycle the gate counter decrements from 1, so that GATE lasts exactly N cycles.
REQ-010 The accumulator SHALL saturate at 2^CNT_W-1; an edge arriving at saturation SHALL set the overflow flag, and the value SHALL NOT wrap.
REQ-011 In DONE, the block SHALL take the following actions, then return to IDLE next cycle.
  - Register count <= accumulator and overflow <= flag.
  - Assert valid for exactly one cycle.
REQ-012 With start in cycle k and N>0, valid SHALL be high in cycle k+N+1; with N=0, valid SHALL be high in cycle k+1.
REQ-013 busy SHALL be 1 in GATE and DONE and 0 in IDLE.
REQ-014 start asserted in GATE or DONE SHALL be ignored, with no queuing.
REQ-015 count and overflow SHALL hold their values between valid pulses; a new start SHALL NOT clear them until the next DONE.
REQ-016 gate_cycles SHALL be sampled only at start; changes during GATE SHALL have no effect.

Reset
REQ-017 With rst_n=0, the following SHALL hold.
  - The FSM is in IDLE.
  - count=0, valid=0, busy=0, overflow=0.
  - The synchronizer, edge-detector, gate-counter and accumulator flops are all 0.
REQ-018 Reset asserted mid-GATE SHALL abort the measurement with no valid pulse; after release, the block SHALL wait for a fresh start.

Configuration
REQ-019 The macro RO_CONTINUOUS_EN SHALL select the restart behaviour.
  - Defined: DONE SHALL go directly to GATE, reloading the gate counter from the current gate_cycles and clearing the accumulator, so measurements free-run after the first start.
  - Defined, with gate_cycles=0 at reload: the block SHALL return to IDLE.
  - Defined: busy SHALL remain 1 between back-to-back windows.
  - Undefined: the single-shot behaviour of REQ-011 applies.

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
  - Basic: ro_in period 4 clk; start with N=100 -> valid at start+101; count 25 +/-1; overflow 0.
  - Zero gate: start with N=0 -> valid at start+1; count=0; overflow=0; busy high for exactly one cycle.
  - Saturation (CNT_W=8): ro_in period 2 clk; N=1000 -> count=255, overflow=1.
  - Reset abort: reset pulse at GATE cycle 50 of N=100 -> no valid; all outputs 0; idle until the next start.
  - Busy ignore: second start at GATE cycle 10 with N=5 -> exactly one valid, at first start+N1+1, using the original N1.
  - Continuous (RO_CONTINUOUS_EN): one start with N=20, ro_in period 4 -> valid every 21 cycles, count 5 +/-1, busy stays 1.
